// File: rtl/ll_multi_fifo.sv
// ll_multi_fifo
// Shared-buffer multi-queue FIFO. NUM_FIFOS logical queues share one
// DEPTH-entry data store. Per-entry next pointers thread one linked list per
// queue plus a free list of unallocated entries.
//
// Ports:
//   clk          sole clock, all state updates on posedge
//   rst          asynchronous active-high reset
//   push         enqueue request into queue push_sel with word data_in
//   pop          dequeue request from queue pop_sel
//   full         no free entries left
//   empty        bit i set when queue i holds no words
//   count        flattened per-queue occupancy, queue 0 in the LSBs
//   free_count   number of unallocated entries
//   data_out     popped / head word
//   data_out_vld data_out valid
//   err          sticky flag for rejected (illegal) requests
//
// Build option LLFIFO_REG_OUT_EN:
//   defined   -> data_out/data_out_vld registered, valid the cycle after an
//                accepted pop, data_out holds its last value otherwise
//   undefined -> data_out is the head word of pop_sel combinationally,
//                data_out_vld = ~empty[pop_sel]
module ll_multi_fifo #(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 4,
    parameter int NUM_FIFOS = 2,
    parameter int PTR_WIDTH = $clog2(DEPTH),
    parameter int SEL_WIDTH = $clog2(NUM_FIFOS)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 push,
    input  logic [SEL_WIDTH-1:0]                 push_sel,
    input  logic [WIDTH-1:0]                     data_in,
    input  logic                                 pop,
    input  logic [SEL_WIDTH-1:0]                 pop_sel,
    output logic                                 full,
    output logic [NUM_FIFOS-1:0]                 empty,
    output logic [NUM_FIFOS*(PTR_WIDTH+1)-1:0]   count,
    output logic [PTR_WIDTH:0]                   free_count,
    output logic [WIDTH-1:0]                     data_out,
    output logic                                 data_out_vld,
    output logic                                 err
);

    localparam int          CW  = PTR_WIDTH + 1;
    localparam int unsigned ND  = DEPTH;
    localparam int unsigned NQ  = NUM_FIFOS;
    localparam int unsigned NSL = 1 << SEL_WIDTH;

    logic [WIDTH-1:0]     mem       [DEPTH];
    logic [PTR_WIDTH-1:0] nxt       [DEPTH];
    logic [PTR_WIDTH-1:0] head      [NUM_FIFOS];
    logic [PTR_WIDTH-1:0] tail      [NUM_FIFOS];
    logic [CW-1:0]        cnt       [NUM_FIFOS];
    logic [PTR_WIDTH-1:0] free_head_r;
    logic [PTR_WIDTH-1:0] free_tail_r;
    logic [CW-1:0]        free_cnt;
    logic                 err_r;

    logic [NSL-1:0]       sel_ok;
    logic [NUM_FIFOS-1:0] empty_vec;
    logic [NUM_FIFOS-1:0] push_hit;
    logic [NUM_FIFOS-1:0] pop_hit;
    logic                 push_acc;
    logic                 pop_acc;
    logic [PTR_WIDTH-1:0] push_e;
    logic [PTR_WIDTH-1:0] pop_h;

    // Select codes beyond NUM_FIFOS are invalid; a lookup avoids comparing
    // a narrow select against a constant it can never reach.
    always_comb begin
        sel_ok = '0;
        for (int unsigned i = 0; i < NSL; i++) begin
            sel_ok[i] = (i < NQ);
        end
    end

    always_comb begin
        empty_vec = '0;
        for (int unsigned q = 0; q < NQ; q++) begin
            empty_vec[q] = (cnt[q] == '0);
        end
    end

    assign push_acc = push & sel_ok[push_sel] & (free_cnt != '0);
    assign pop_acc  = pop & sel_ok[pop_sel] & ~empty_vec[pop_sel];
    assign push_e   = free_head_r;
    assign pop_h    = head[pop_sel];

    always_comb begin
        push_hit = '0;
        pop_hit  = '0;
        for (int unsigned q = 0; q < NQ; q++) begin
            push_hit[q] = push_acc && (push_sel == SEL_WIDTH'(q));
            pop_hit[q]  = pop_acc && (pop_sel == SEL_WIDTH'(q));
        end
    end

    // Data store is intentionally not reset.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[push_e] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ND; i++) begin
                nxt[i] <= PTR_WIDTH'(i + 1);
            end
            for (int unsigned q = 0; q < NQ; q++) begin
                head[q] <= '0;
                tail[q] <= '0;
                cnt[q]  <= '0;
            end
            free_head_r <= '0;
            free_tail_r <= PTR_WIDTH'(ND - 1);
            free_cnt    <= CW'(ND);
            err_r       <= 1'b0;
        end else begin
            if ((push && !push_acc) || (pop && !pop_acc)) begin
                err_r <= 1'b1;
            end

            // Per-queue lists. A same-queue push/pop at count 1 cannot go
            // through next[h] (it is written this same edge), so the pushed
            // entry becomes head directly.
            for (int unsigned q = 0; q < NQ; q++) begin
                if (push_hit[q] &&
                    ((cnt[q] == '0) || (pop_hit[q] && cnt[q] == CW'(1)))) begin
                    head[q] <= push_e;
                end else if (pop_hit[q]) begin
                    head[q] <= nxt[head[q]];
                end
                if (push_hit[q]) begin
                    tail[q] <= push_e;
                end
                if (push_hit[q] && !pop_hit[q]) begin
                    cnt[q] <= cnt[q] + CW'(1);
                end else if (pop_hit[q] && !push_hit[q]) begin
                    cnt[q] <= cnt[q] - CW'(1);
                end
            end

            // Link the freed entry behind the free tail only when the free
            // list stays non-empty after this edge; otherwise it restarts
            // as a single-entry list below.
            if (pop_acc && (free_cnt != '0) &&
                !(push_acc && free_cnt == CW'(1))) begin
                nxt[free_tail_r] <= pop_h;
            end
            if (push_acc && (cnt[push_sel] != '0)) begin
                nxt[tail[push_sel]] <= push_e;
            end

            if (push_acc) begin
                if (pop_acc && free_cnt == CW'(1)) begin
                    free_head_r <= pop_h;
                end else begin
                    free_head_r <= nxt[push_e];
                end
            end else if (pop_acc && free_cnt == '0) begin
                free_head_r <= pop_h;
            end
            if (pop_acc) begin
                free_tail_r <= pop_h;
            end

            if (push_acc && !pop_acc) begin
                free_cnt <= free_cnt - CW'(1);
            end else if (pop_acc && !push_acc) begin
                free_cnt <= free_cnt + CW'(1);
            end
        end
    end

    assign full       = (free_cnt == '0);
    assign empty      = empty_vec;
    assign free_count = free_cnt;
    assign err        = err_r;

    always_comb begin
        count = '0;
        for (int unsigned q = 0; q < NQ; q++) begin
            count[q*CW +: CW] = cnt[q];
        end
    end

`ifdef LLFIFO_REG_OUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out     <= '0;
            data_out_vld <= 1'b0;
        end else begin
            data_out_vld <= pop_acc;
            if (pop_acc) begin
                data_out <= mem[pop_h];
            end
        end
    end
`else
    assign data_out     = mem[pop_h];
    assign data_out_vld = sel_ok[pop_sel] & ~empty_vec[pop_sel];
`endif

endmodule

// File: tb/tb_ll_multi_fifo.sv
// Testbench for ll_multi_fifo: directed scenarios with literal expectations
// plus randomized traffic checked against a queue-based reference model.
// Works in both LLFIFO_REG_OUT_EN builds.
module tb_ll_multi_fifo;

    localparam int W  = 4;
    localparam int D  = 4;
    localparam int N  = 2;
    localparam int PW = 2;
    localparam int SW = 1;
    localparam int CW = PW + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             push = 1'b0;
    logic [SW-1:0]    push_sel = '0;
    logic [W-1:0]     data_in = '0;
    logic             pop = 1'b0;
    logic [SW-1:0]    pop_sel = '0;
    logic             full;
    logic [N-1:0]     empty;
    logic [N*CW-1:0]  count;
    logic [CW-1:0]    free_count;
    logic [W-1:0]     data_out;
    logic             data_out_vld;
    logic             err;

    ll_multi_fifo #(
        .WIDTH(W),
        .DEPTH(D),
        .NUM_FIFOS(N)
    ) dut (
        .clk(clk),
        .rst(rst),
        .push(push),
        .push_sel(push_sel),
        .data_in(data_in),
        .pop(pop),
        .pop_sel(pop_sel),
        .full(full),
        .empty(empty),
        .count(count),
        .free_count(free_count),
        .data_out(data_out),
        .data_out_vld(data_out_vld),
        .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: one plain queue per logical FIFO.
    logic [W-1:0] mq [N][$];
    bit           err_m;
    logic [W-1:0] last_dout;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_state();
        int total;
        int sum;
        total = mq[0].size() + mq[1].size();
        sum = 0;
        for (int q = 0; q < N; q++) begin
            chk($sformatf("empty%0d", q), empty[q], mq[q].size() == 0);
            chk($sformatf("count%0d", q), count[q*CW +: CW], mq[q].size());
            sum += int'(count[q*CW +: CW]);
        end
        chk("free_count", free_count, D - total);
        chk("full", full, total == D);
        chk("err", err, err_m);
        chk("invariant", sum + int'(free_count), D);
    endtask

    // One clock of traffic. Starts away from posedge; returns after the
    // following negedge. got is the word the DUT presented for the pop.
    task automatic step(input bit pu, input int ps, input logic [W-1:0] din,
                        input bit po, input int pos, output logic [W-1:0] got);
        bit           pacc;
        bit           oacc;
        logic [W-1:0] exp_pop;
        logic [W-1:0] tmp;
        push     = pu;
        push_sel = SW'(ps);
        data_in  = din;
        pop      = po;
        pop_sel  = SW'(pos);
        pacc     = pu && (mq[0].size() + mq[1].size() < D);
        oacc     = po && (mq[pos].size() > 0);
        exp_pop  = oacc ? mq[pos][0] : '0;
        got      = '0;
        #1;
`ifndef LLFIFO_REG_OUT_EN
        chk("dout_vld", data_out_vld, mq[pos].size() > 0);
        if (mq[pos].size() > 0) chk("dout", data_out, mq[pos][0]);
        got = data_out;
`endif
        @(posedge clk);
        if (oacc) tmp = mq[pos].pop_front();
        if (pacc) mq[ps].push_back(din);
        if ((pu && !pacc) || (po && !oacc)) err_m = 1'b1;
        @(negedge clk);
`ifdef LLFIFO_REG_OUT_EN
        chk("dout_vld", data_out_vld, oacc);
        if (oacc) last_dout = exp_pop;
        chk("dout", data_out, last_dout);
        got = data_out;
`endif
        push = 1'b0;
        pop  = 1'b0;
        check_state();
    endtask

    // Asynchronous reset pulse applied between clock edges; outputs are
    // checked while reset is still asserted.
    task automatic reset_dut();
        push = 1'b0;
        pop  = 1'b0;
        rst  = 1'b1;
        #2;
        mq[0].delete();
        mq[1].delete();
        err_m     = 1'b0;
        last_dout = '0;
        chk("rst_full", full, 0);
        chk("rst_empty", empty, 2'b11);
        chk("rst_free", free_count, D);
        chk("rst_err", err, 0);
        chk("rst_vld", data_out_vld, 0);
`ifdef LLFIFO_REG_OUT_EN
        chk("rst_dout", data_out, 0);
`endif
        rst = 1'b0;
    endtask

    initial begin
        logic [W-1:0] g;
        logic [W-1:0] vals [4];
        vals[0] = 4'hA; vals[1] = 4'hB; vals[2] = 4'hC; vals[3] = 4'hD;
        err_m = 1'b0;
        last_dout = '0;

        @(negedge clk);
        reset_dut();

        // Fill queue 0 then drain it in order.
        for (int i = 0; i < 4; i++) step(1, 0, vals[i], 0, 0, g);
        chk("tp1_full", full, 1);
        chk("tp1_free", free_count, 0);
        chk("tp1_count0", count[CW-1:0], 4);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1, 0, g);
            chk("tp1_pop", g, vals[i]);
        end
        chk("tp1_empty", empty, 2'b11);

        // Interleaved pushes stay in their own queues.
        step(1, 0, 4'd1, 0, 0, g);
        step(1, 1, 4'd7, 0, 0, g);
        step(1, 0, 4'd2, 0, 0, g);
        step(1, 1, 4'd8, 0, 0, g);
        step(0, 0, 0, 1, 1, g); chk("tp2_q1a", g, 7);
        step(0, 0, 0, 1, 1, g); chk("tp2_q1b", g, 8);
        step(0, 0, 0, 1, 0, g); chk("tp2_q0a", g, 1);
        step(0, 0, 0, 1, 0, g); chk("tp2_q0b", g, 2);

        // Same-queue push/pop at count 1.
        step(1, 0, 4'd5, 0, 0, g);
        step(1, 0, 4'd9, 1, 0, g);
        chk("tp3_pop", g, 5);
        chk("tp3_count0", count[CW-1:0], 1);
        step(0, 0, 0, 1, 0, g);
        chk("tp3_next", g, 9);

        // Full buffer: push is rejected even with a simultaneous pop.
        step(1, 0, 4'd1, 0, 0, g);
        step(1, 0, 4'd2, 0, 0, g);
        step(1, 1, 4'd3, 0, 0, g);
        step(1, 1, 4'd4, 0, 0, g);
        chk("tp4_full", full, 1);
        step(1, 0, 4'd6, 1, 1, g);
        chk("tp4_pop", g, 3);
        chk("tp4_err", err, 1);
        chk("tp4_free", free_count, 1);
        step(1, 0, 4'hE, 0, 0, g);
        chk("tp4_refill", free_count, 0);
        step(0, 0, 0, 1, 0, g); chk("tp4_q0a", g, 1);
        step(0, 0, 0, 1, 0, g); chk("tp4_q0b", g, 2);
        step(0, 0, 0, 1, 0, g); chk("tp4_q0c", g, 4'hE);

        // Pop of an empty queue, then reset mid-stream.
        reset_dut();
        step(1, 0, 4'd3, 0, 0, g);
        step(0, 0, 0, 1, 1, g);
        chk("tp5_err", err, 1);
        chk("tp5_count", count, 3'd1);
        step(1, 1, 4'd6, 0, 0, g);
        reset_dut();

        // Randomized traffic against the model.
        for (int n = 0; n < 10000; n++) begin
            bit pu;
            bit po;
            if (n % 2500 == 2499) reset_dut();
            pu = ($urandom_range(0, 99) < 55);
            po = ($urandom_range(0, 99) < 50);
            step(pu, int'($urandom_range(0, N - 1)), W'($urandom),
                 po, int'($urandom_range(0, N - 1)), g);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ll_multi_fifo.md
# ll_multi_fifo

Parametrised shared-buffer multi-queue FIFO: NUM_FIFOS logical FIFOs share one DEPTH-entry data store, with per-entry next pointers forming one linked list per queue plus a free list. It generalises the existing two-queue linked-list FIFO with several additions:
- per-queue occupancy counts and a free-entry count
- well-defined simultaneous push/pop on any queue pair, including the same queue
- sticky error reporting for illegal requests
- an optional registered read port

It sits between traffic sources and a single arbitrated consumer.

## Interface
- WIDTH, 4, data word width
- DEPTH, 4, shared entries (≥2)
- NUM_FIFOS, 2, logical queues (≥2)
- PTR_WIDTH, $clog2(DEPTH), entry pointer width
- SEL_WIDTH, $clog2(NUM_FIFOS), queue select width
- clk  in  1  sole clock; all state updates on posedge
- rst  in  1  reset, asynchronous and active-high
- push  in  1  enqueue request
- push_sel  in  SEL_WIDTH  target queue of push
- data_in  in  WIDTH  word to enqueue
- pop  in  1  dequeue request
- pop_sel  in  SEL_WIDTH  source queue of pop
- full  out  1  free list empty (free_count==0)
- empty  out  NUM_FIFOS  bit i set when count of queue i is 0
- count  out  NUM_FIFOS*(PTR_WIDTH+1)  flattened per-queue occupancy, queue 0 in LSBs
- free_count  out  PTR_WIDTH+1  unallocated entries
- data_out  out  WIDTH  popped / head word (see Configuration)
- data_out_vld  out  1  data_out valid
- err  out  1  sticky illegal-request flag

## Operation
- State:
  - data RAM (not reset)
  - next[DEPTH]
  - per-queue head, tail, count
  - free_head, free_tail, free_count
  - err
- Reset (async, asserted while rst=1): next[i]=i+1 (last entry don't-care), free_head=0, free_tail=DEPTH-1, free_count=DEPTH, all count=0, head/tail=0, err=0. Outputs during reset: full=0, empty=all 1s, data_out_vld=0, err=0, data_out=0 when LLFIFO_REG_OUT_EN.
- Accept rules:
  - push accepted iff push & ~full.
  - pop accepted iff pop & ~empty[pop_sel].
  - Rejected requests change no queue state and set err (sticky until rst).
  - push_sel ≥ NUM_FIFOS or pop_sel ≥ NUM_FIFOS with its request high is rejected the same way.
- Accepted push to queue q, using entry e=free_head:
  - data[e]=data_in
  - if count[q]==0 then head[q]=e, else next[tail[q]]=e
  - tail[q]=e
  - free_head=next[e]
- Accepted pop from queue p, freeing entry h=head[p]:
  - head[p]=next[h]
  - h appended to free list: next[free_tail]=h, free_tail=h
- Counts: count[q] += push_acc(q) − pop_acc(q); free_count += pop_acc − push_acc. Net zero when push and pop hit the same queue.
- Simultaneous-event boundaries:
  - Push/pop same queue with count==1: the popped entry leaves, the pushed entry becomes both head and tail, and count stays 1.
  - Push takes the last free entry while a pop frees h: free_head=free_tail=h, free_count stays 1, full stays 0.
  - Pop frees an entry when free_count==0: free_head=free_tail=h.
  - Full with a simultaneous pop: push is still rejected, because acceptance uses the pre-edge full.
- Invariant (bench checks every cycle): sum(count)+free_count==DEPTH.

## Timing
- No handshake stall: accepted operations commit on the same posedge.
- full, empty, count and free_count reflect the post-edge state. There is no combinational path from push/pop to these outputs.
- Back-to-back push/pop every cycle is supported on any queues. Throughput is 1 push plus 1 pop per cycle.
- Async reset mid-operation discards all queued data. The first legal push is accepted on the first posedge after rst deasserts.

## Configuration
- LLFIFO_REG_OUT_EN defined:
  - data_out/data_out_vld are registered.
  - The cycle after an accepted pop: data_out_vld=1 and data_out=popped word.
  - Otherwise data_out_vld=0 and data_out holds its last value.
  - Read latency is 1 cycle.
- Undefined:
  - data_out=data[head[pop_sel]] combinationally.
  - data_out_vld=~empty[pop_sel] (valid pop_sel).
  - The word is valid in the same cycle as the pop (0-cycle latency).

## Test plan
- Reset then 4 pushes to queue 0 (A,B,C,D), WIDTH=4, DEPTH=4 -> full=1, free_count=0, count0=4; 4 pops return A,B,C,D in order; empty=2'b11.
- Interleave pushes: q0 gets 1,2 and q1 gets 7,8 (alternating) -> pops q1 return 7,8 and pops q0 return 1,2; no cross-queue mixing.
- q0 holds one word 5; push 9 to q0 and pop q0 in the same cycle -> pop yields 5, count0 stays 1, next pop yields 9.
- Full buffer; pop q1 and push to q0 in the same cycle -> push rejected, err=1, free_count=1; a following push succeeds, reusing the freed entry.
- Pop empty q1 -> err=1, all counts unchanged; assert rst asynchronously mid-stream -> err=0, free_count=4, empty=all 1s before the next clock edge.
- Random legal traffic for 10k cycles -> sum(count)+free_count==DEPTH every cycle, and per-queue order matches the reference model in both LLFIFO_REG_OUT_EN builds.
